ref_win_mem: RTL and testbench

Parametrised reference-pixel window memory for the integer ME array. NUM_BANKS pixel columns, each a DEPTH-row bank with its own write row, so the loader can fill diagonally skewed data. Adds a circular window base for sliding-window reuse: logical rows map to physical rows modulo DEPTH. Reads go through a 2-stage pipeline and return either RD_ROWS rows at once or a single selected row to the PE array.

---
 rtl/ref_win_mem_pkg.sv | 19 +
 rtl/ref_win_mem_if.sv | 35 +++
 rtl/ref_win_mem_bank.sv | 33 +++
 rtl/ref_win_mem.sv | 125 ++++++++++++
 tb/tb_ref_win_mem.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ref_win_mem_pkg.sv
// Shared constants and helpers for the reference-pixel window memory.
package ref_mem_pkg;

  localparam int PIXEL_DEF     = 8;
  localparam int NUM_BANKS_DEF = 32;
  localparam int DEPTH_DEF     = 128;
  localparam int RD_ROWS_DEF   = 8;

  // rd_mode encoding
  localparam logic RD_MULTI  = 1'b0;
  localparam logic RD_SINGLE = 1'b1;

  // Modulo-DEPTH add; DEPTH is a power of two so masking gives the wrap.
  function automatic logic [31:0] wrap_add(input logic [31:0] a, input logic [31:0] b,
                                           input int depth);
    return (a + b) & 32'(depth - 1);
  endfunction

endpackage

// File: rtl/ref_win_mem_if.sv
// Write / window / read bus of the reference window memory.
interface ref_win_mem_if #(
  parameter int PIXEL     = 8,
  parameter int NUM_BANKS = 32,
  parameter int DEPTH     = 128,
  parameter int RD_ROWS   = 8
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(RD_ROWS);

  logic [NUM_BANKS*PIXEL-1:0]         wr_data;
  logic [NUM_BANKS-1:0]               wr_mask;
  logic [NUM_BANKS*AW-1:0]            wr_row_all;
  logic                               adv_en;
  logic [AW-1:0]                      adv_rows;
  logic                               rd_en;
  logic                               rd_mode;
  logic [AW-1:0]                      rd_row;
  logic [SW-1:0]                      rd_sel;
  logic [RD_ROWS*NUM_BANKS*PIXEL-1:0] rd_data_multi;
  logic                               rd_multi_valid;
  logic [NUM_BANKS*PIXEL-1:0]         rd_data_single;
  logic                               rd_single_valid;
  logic [AW-1:0]                      base_row;

  modport master (
    output wr_data, wr_mask, wr_row_all, adv_en, adv_rows, rd_en, rd_mode, rd_row, rd_sel,
    input  rd_data_multi, rd_multi_valid, rd_data_single, rd_single_valid, base_row
  );

  modport slave (
    input  wr_data, wr_mask, wr_row_all, adv_en, adv_rows, rd_en, rd_mode, rd_row, rd_sel,
    output rd_data_multi, rd_multi_valid, rd_data_single, rd_single_valid, base_row
  );
endinterface

// File: rtl/ref_win_mem_bank.sv
// One pixel column: DEPTH x PIXEL array, one write port, RD_ROWS read-first registered reads.
module ref_mem_bank
  import ref_mem_pkg::*;
#(
  parameter int PIXEL   = PIXEL_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int RD_ROWS = RD_ROWS_DEF,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_row,
  input  logic [PIXEL-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [RD_ROWS*AW-1:0]    rd_rows,
  output logic [RD_ROWS*PIXEL-1:0] rd_data
);

  logic [PIXEL-1:0] mem [DEPTH];

  // Array write and registered read; NBA ordering makes a same-edge read see old data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
    if (rd_en) begin
      for (int r = 0; r < RD_ROWS; r++) begin
        rd_data[r*PIXEL +: PIXEL] <= mem[rd_rows[r*AW +: AW]];
      end
    end
  end

endmodule

// File: rtl/ref_win_mem.sv
// Reference-pixel window memory: per-bank skewed writes, circular window base, 2-stage reads.
module ref_win_mem
  import ref_mem_pkg::*;
#(
  parameter int PIXEL     = PIXEL_DEF,
  parameter int NUM_BANKS = NUM_BANKS_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int RD_ROWS   = RD_ROWS_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  ref_win_mem_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int SW    = $clog2(RD_ROWS);
  localparam int ROW_W = NUM_BANKS * PIXEL;

  logic [AW-1:0]              base_row_reg;
  logic [RD_ROWS*AW-1:0]      rd_phys;
  logic [RD_ROWS*PIXEL-1:0]   bank_rd [NUM_BANKS];
  logic [RD_ROWS*ROW_W-1:0]   multi_row;
  logic [ROW_W-1:0]           single_row;
  logic                       s1_valid;
  logic                       s1_mode;
  logic [SW-1:0]              s1_sel;
  logic [RD_ROWS*ROW_W-1:0]   multi_reg;
  logic [ROW_W-1:0]           single_reg;
  logic                       multi_valid_reg;
  logic                       single_valid_reg;

  // The read window is always the RD_ROWS rows from rd_row; single reads pick one later.
  generate
    for (genvar gi = 0; gi < RD_ROWS; gi++) begin : g_rd_addr
      assign rd_phys[gi*AW +: AW] =
        AW'(wrap_add(32'(base_row_reg), 32'(bus.rd_row) + 32'(gi), DEPTH));
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic [AW-1:0] wr_phys;
      assign wr_phys = AW'(wrap_add(32'(base_row_reg), 32'(bus.wr_row_all[gi*AW +: AW]), DEPTH));

      ref_mem_bank #(
        .PIXEL   (PIXEL),
        .DEPTH   (DEPTH),
        .RD_ROWS (RD_ROWS),
        .AW      (AW)
      ) u_bank (
        .clk     (clk),
        .wr_en   (bus.wr_mask[gi]),
        .wr_row  (wr_phys),
        .wr_data (bus.wr_data[gi*PIXEL +: PIXEL]),
        .rd_en   (bus.rd_en),
        .rd_rows (rd_phys),
        .rd_data (bank_rd[gi])
      );

      for (genvar gj = 0; gj < RD_ROWS; gj++) begin : g_row
        assign multi_row[gj*ROW_W + gi*PIXEL +: PIXEL] = bank_rd[gi][gj*PIXEL +: PIXEL];
      end
    end
  endgenerate

  // Single-row pick from the stage-1 window using the captured offset.
  always_comb begin
    single_row = '0;
    for (int r = 0; r < RD_ROWS; r++) begin
      if (s1_sel == SW'(r)) begin
        single_row = multi_row[r*ROW_W +: ROW_W];
      end
    end
  end

  // Window base advance; concurrent writes/reads already used the old base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_row_reg <= '0;
    end else if (bus.adv_en) begin
      base_row_reg <= base_row_reg + bus.adv_rows;
    end
  end

  // Stage 1: capture the request alongside the bank reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= RD_MULTI;
      s1_sel   <= '0;
    end else begin
      s1_valid <= bus.rd_en;
      if (bus.rd_en) begin
        s1_mode <= bus.rd_mode;
        s1_sel  <= bus.rd_sel;
      end
    end
  end

  // Stage 2: load only the selected mode's output; the other one holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multi_reg        <= '0;
      single_reg       <= '0;
      multi_valid_reg  <= 1'b0;
      single_valid_reg <= 1'b0;
    end else begin
      multi_valid_reg  <= s1_valid && (s1_mode == RD_MULTI);
      single_valid_reg <= s1_valid && (s1_mode == RD_SINGLE);
      if (s1_valid && (s1_mode == RD_MULTI)) begin
        multi_reg <= multi_row;
      end
      if (s1_valid && (s1_mode == RD_SINGLE)) begin
        single_reg <= single_row;
      end
    end
  end

  assign bus.rd_data_multi   = multi_reg;
  assign bus.rd_multi_valid  = multi_valid_reg;
  assign bus.rd_data_single  = single_reg;
  assign bus.rd_single_valid = single_valid_reg;
  assign bus.base_row        = base_row_reg;

endmodule

// File: tb/tb_ref_win_mem.sv
// Scoreboard bench for ref_win_mem: directed scenarios plus random traffic vs. an array model.
module tb_ref_win_mem;
  import ref_mem_pkg::*;

  localparam int P  = PIXEL_DEF;
  localparam int NB = NUM_BANKS_DEF;
  localparam int D  = DEPTH_DEF;
  localparam int RR = RD_ROWS_DEF;
  localparam int AW = $clog2(D);
  localparam int RW = NB * P;

  typedef struct {
    bit              single;
    logic [RR*RW-1:0] data;
    int              due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ref_win_mem_if bus ();

  ref_win_mem dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Model state: plain memory indexed [physical row][bank] and an integer base.
  logic [P-1:0] mem [D][NB];
  int base = 0;
  int cyc = 0;
  exp_t q[$];
  logic [RR*RW-1:0] last_multi = '0;
  logic [RW-1:0] last_single = '0;
  int errors = 0;
  int checks = 0;

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // What the spec says happens at one clock edge: read-first, old base for everything.
  task automatic model_edge();
    exp_t e;
    int phys;
    cyc++;
    if (bus.rd_en) begin
      e.single = bus.rd_mode;
      e.data = '0;
      e.due = cyc + 1;
      if (bus.rd_mode == RD_MULTI) begin
        for (int r = 0; r < RR; r++) begin
          phys = (base + int'(bus.rd_row) + r) % D;
          for (int b = 0; b < NB; b++) e.data[(r*NB + b)*P +: P] = mem[phys][b];
        end
      end else begin
        phys = (base + int'(bus.rd_row) + int'(bus.rd_sel)) % D;
        for (int b = 0; b < NB; b++) e.data[b*P +: P] = mem[phys][b];
      end
      q.push_back(e);
    end
    for (int b = 0; b < NB; b++) begin
      if (bus.wr_mask[b]) begin
        phys = (base + int'(bus.wr_row_all[b*AW +: AW])) % D;
        mem[phys][b] = bus.wr_data[b*P +: P];
      end
    end
    if (bus.adv_en) base = (base + int'(bus.adv_rows)) % D;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    bus.wr_mask = '0;
    bus.adv_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic set_write(input int row, input logic [P-1:0] pix, input logic [NB-1:0] mask);
    for (int b = 0; b < NB; b++) begin
      bus.wr_row_all[b*AW +: AW] = AW'(row);
      bus.wr_data[b*P +: P] = pix;
    end
    bus.wr_mask = mask;
  endtask

  task automatic set_read(input logic mode, input int row, input int sel);
    bus.rd_en = 1'b1;
    bus.rd_mode = mode;
    bus.rd_row = AW'(row);
    bus.rd_sel = 3'(sel);
  endtask

  task automatic set_adv(input int rows);
    bus.adv_en = 1'b1;
    bus.adv_rows = AW'(rows);
  endtask

  task automatic check_reset_state(input string tag);
    check_int({tag, "_base"}, int'(bus.base_row), 0);
    check_int({tag, "_mvalid"}, int'(bus.rd_multi_valid), 0);
    check_int({tag, "_svalid"}, int'(bus.rd_single_valid), 0);
    check_int({tag, "_mdata_zero"}, int'(bus.rd_data_multi == '0), 1);
    check_int({tag, "_sdata_zero"}, int'(bus.rd_data_single == '0), 1);
  endtask

  // Monitor: compares every presented output against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      check_int("base_row", int'(bus.base_row), base);
      if (bus.rd_multi_valid && bus.rd_single_valid) begin
        errors++;
        $display("FAIL both_valid got=1 want=0");
      end
      if (bus.rd_multi_valid || bus.rd_single_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid at cycle %0d (multi=%0b single=%0b)", cyc,
                   bus.rd_multi_valid, bus.rd_single_valid);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_int("latency_cycle", cyc, e.due);
          check_int("mode_single", int'(bus.rd_single_valid), int'(e.single));
          if (!e.single) begin
            checks++;
            if (bus.rd_data_multi !== e.data) begin
              errors++;
              for (int r = 0; r < RR; r++) begin
                if (bus.rd_data_multi[r*RW +: RW] !== e.data[r*RW +: RW]) begin
                  $display("FAIL multi_data row=%0d got=%h want=%h", r,
                           bus.rd_data_multi[r*RW +: RW], e.data[r*RW +: RW]);
                  break;
                end
              end
            end
            checks++;
            if (bus.rd_data_single !== last_single) begin
              errors++;
              $display("FAIL single_hold got=%h want=%h", bus.rd_data_single, last_single);
            end
            last_multi = e.data;
          end else begin
            checks++;
            if (bus.rd_data_single !== e.data[RW-1:0]) begin
              errors++;
              $display("FAIL single_data got=%h want=%h", bus.rd_data_single, e.data[RW-1:0]);
            end
            checks++;
            if (bus.rd_data_multi !== last_multi) begin
              errors++;
              $display("FAIL multi_hold row0 got=%h want=%h", bus.rd_data_multi[RW-1:0],
                       last_multi[RW-1:0]);
            end
            last_single = e.data[RW-1:0];
          end
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_valid got=none want=%s due=%0d now=%0d",
                 e.single ? "single" : "multi", e.due, cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < D; r++) for (int b = 0; b < NB; b++) mem[r][b] = '0;
    bus.wr_data = '0;
    bus.wr_mask = '0;
    bus.wr_row_all = '0;
    bus.adv_en = 1'b0;
    bus.adv_rows = '0;
    bus.rd_en = 1'b0;
    bus.rd_mode = RD_MULTI;
    bus.rd_row = '0;
    bus.rd_sel = '0;

    repeat (3) @(posedge clk);
    #3;
    check_reset_state("reset");
    rst_n = 1'b1;

    // Fill every row so no read ever touches unwritten storage: row r = r+1.
    for (int r = 0; r < D; r++) begin
      set_write(r, P'(r + 1), '1);
      tick();
    end
    set_read(RD_MULTI, 0, 0);
    tick();
    repeat (3) tick();

    // Bank masking on row 0.
    set_write(0, 8'h01, 32'h0000000F);
    tick();
    set_write(0, 8'h02, 32'h000000F0);
    tick();
    set_read(RD_SINGLE, 0, 0);
    tick();
    repeat (3) tick();

    // Skewed write: bank b writes row b with value b, then back-to-back single reads.
    for (int b = 0; b < NB; b++) begin
      bus.wr_row_all[b*AW +: AW] = AW'(b);
      bus.wr_data[b*P +: P] = P'(b);
    end
    bus.wr_mask = '1;
    tick();
    for (int r = 0; r < NB; r++) begin
      set_read(RD_SINGLE, r - (r % RR), r % RR);
      tick();
    end
    repeat (3) tick();

    // Wrap-around multi-row read.
    for (int r = 120; r < 128; r++) begin
      set_write(r, P'(8'hA0 + r - 120), '1);
      tick();
    end
    for (int r = 0; r < 8; r++) begin
      set_write(r, P'(8'hB0 + r), '1);
      tick();
    end
    set_read(RD_MULTI, 124, 0);
    tick();
    repeat (3) tick();

    // Window advance, including wrap of the base itself.
    set_adv(16);
    tick();
    set_read(RD_SINGLE, 0, 3);
    tick();
    set_adv(120);
    tick();
    check_int("base_after_wrap", int'(bus.base_row), 8);
    set_adv(0);
    tick();
    set_adv(120);
    tick();
    repeat (3) tick();

    // Write/read collision on row 5, then the follow-up read sees the new data.
    set_write(5, 8'hFF, '1);
    set_read(RD_SINGLE, 5, 0);
    tick();
    set_read(RD_SINGLE, 5, 0);
    tick();
    // Read and advance on the same edge: the read uses the old base.
    set_read(RD_MULTI, 3, 0);
    set_adv(7);
    tick();
    // Back-to-back alternating modes.
    for (int i = 0; i < 4; i++) begin
      set_read((i % 2) ? RD_SINGLE : RD_MULTI, 10 * i + 1, i);
      tick();
    end
    repeat (3) tick();

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      for (int w = 0; w < RW / 32; w++) bus.wr_data[w*32 +: 32] = $urandom();
      for (int b = 0; b < NB; b++) bus.wr_row_all[b*AW +: AW] = AW'($urandom_range(0, D - 1));
      case ($urandom_range(0, 3))
        0: bus.wr_mask = '0;
        1: bus.wr_mask = '1;
        default: bus.wr_mask = NB'($urandom());
      endcase
      if ($urandom_range(0, 7) == 0) set_adv($urandom_range(0, D - 1));
      if ($urandom_range(0, 9) < 7)
        set_read(logic'($urandom_range(0, 1)), $urandom_range(0, D - 1), $urandom_range(0, RR - 1));
      tick();
    end
    repeat (3) tick();

    // Reset while a read is in flight: the request must be dropped.
    set_read(RD_MULTI, 2, 0);
    tick();
    #2;
    rst_n = 1'b0;
    q.delete();
    base = 0;
    last_multi = '0;
    last_single = '0;
    repeat (2) @(posedge clk);
    #3;
    check_reset_state("midread_reset");
    rst_n = 1'b1;
    repeat (4) tick();
    set_read(RD_SINGLE, 7, 1);
    tick();
    repeat (3) tick();

    check_int("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
